conv_sched: RTL

//  Layer sequencer for the binary 3x3 conv engine. For each kernel of the selected layer it:
//   - streams 9 weight bits from the weight ROM into the engine;
//   - starts the sliding window and then the engine;
//   - counts output strobes and waits for the engine done pulse.
//  It then moves to the next kernel and pulses layer_done after the last one.
//  It sits between the top-level control FSM and the window/conv pair.

---
 rtl/conv_sched.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_sched.sv
// conv_sched: layer sequencer for the binary 3x3 conv engine.
// For each kernel of the selected layer it serially loads 9 weight bits from
// the registered weight ROM, starts the sliding window and then the engine,
// counts output strobes and waits for the engine done pulse. layer_done pulses
// after the last kernel when no error was seen.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go, layer_sel   start request (IDLE only) and layer select sampled on go
//   wrom_addr       weight ROM address; wrom_rdata returns one cycle later
//   conv_weight_en  weight-load enable, conv_weight serial weight bit
//   conv_state      latched layer select presented to the engine
//   win_start       sliding-window run enable
//   conv_start      engine run enable
//   conv_ovalid     engine output strobe, conv_done engine completion pulse
//   kernel_idx      kernel currently processed
//   busy            run in progress
//   layer_done      1-cycle pulse on clean layer completion
//   err             sticky strobe-count mismatch / timeout flag
module conv_sched #(
    parameter int unsigned N_KER0    = 4,
    parameter int unsigned N_KER1    = 8,
    parameter int unsigned L1_BASE   = 36,
    parameter int unsigned WADDR_W   = 8,
    parameter int unsigned OUT0      = 676,
    parameter int unsigned OUT1      = 576,
    parameter int unsigned START_GAP = 2,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               layer_sel,
    output logic [WADDR_W-1:0] wrom_addr,
    input  logic               wrom_rdata,
    output logic               conv_weight_en,
    output logic               conv_weight,
    output logic               conv_state,
    output logic               win_start,
    output logic               conv_start,
    input  logic               conv_ovalid,
    input  logic               conv_done,
    output logic [3:0]         kernel_idx,
    output logic               busy,
    output logic               layer_done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  kidx_q,  kidx_d;
    logic [3:0]  cnt_q,   cnt_d;    // WLOAD cycle index c, ARM gap counter
    logic [9:0]  strb_q,  strb_d;   // ovalid strobes seen in RUN
    logic [9:0]  tmo_q,   tmo_d;    // RUN cycles elapsed
    logic        err_q,   err_d;
    logic        layer_q, layer_d;

    logic [9:0]         exp_out;
    logic [3:0]         last_k;
    logic [WADDR_W-1:0] base;

    always_comb begin
        exp_out = layer_q ? 10'(OUT1) : 10'(OUT0);
        last_k  = layer_q ? 4'(N_KER1 - 1) : 4'(N_KER0 - 1);
        base    = layer_q ? WADDR_W'(L1_BASE) : '0;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kidx_q  <= '0;
            cnt_q   <= '0;
            strb_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            layer_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kidx_q  <= kidx_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            layer_q <= layer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        kidx_d  = kidx_q;
        cnt_d   = cnt_q;
        strb_d  = strb_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        layer_d = layer_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    layer_d = layer_sel;
                    kidx_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (cnt_q == 4'd9) begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ARM: begin
                if (cnt_q == 4'(START_GAP - 1)) begin
                    cnt_d   = '0;
                    strb_d  = '0;
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                // A strobe coincident with done is still counted.
                if (conv_ovalid) strb_d = strb_q + 10'd1;
                tmo_d = tmo_q + 10'd1;
                if (conv_done) begin
                    state_d = S_NEXT;
                end else if (tmo_q == 10'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_NEXT: begin
                if (strb_q != exp_out) err_d = 1'b1;
                if (kidx_q == last_k) begin
                    state_d = S_FIN;
                end else begin
                    kidx_d  = kidx_q + 4'd1;
                    cnt_d   = '0;
                    state_d = S_WLOAD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        wrom_addr      = '0;
        conv_weight_en = 1'b0;
        conv_weight    = 1'b0;
        win_start      = 1'b0;
        conv_start     = 1'b0;
        busy           = 1'b1;
        layer_done     = 1'b0;
        unique case (state_q)
            S_IDLE: busy = 1'b0;
            S_WLOAD: begin
                conv_weight_en = 1'b1;
                // ROM is registered: the bit for address issued at c arrives at c+1.
                if (cnt_q <= 4'd8)
                    wrom_addr = base + WADDR_W'(kidx_q) * WADDR_W'(9) + WADDR_W'(cnt_q);
                if (cnt_q != 4'd0) conv_weight = wrom_rdata;
            end
            S_ARM: win_start = 1'b1;
            S_RUN: begin
                win_start  = 1'b1;
                conv_start = 1'b1;
            end
            S_NEXT: ;
            S_FIN: begin
                busy       = 1'b0;
                layer_done = !err_q;
            end
            default: busy = 1'b0;
        endcase
    end

    assign conv_state = layer_q;
    assign kernel_idx = kidx_q;
    assign err        = err_q;

endmodule
